program_loader: RTL and testbench

Upstream boot stage for the stack processor. It accepts a byte-stream program frame over a valid/ready handshake and writes the payload into the processor's 32×8 memory, starting at address 0. It holds the processor in reset until the frame's checksum verifies, then releases it. If the checksum or length is bad, it stays halted with an error flag until restarted.

---
 rtl/program_loader.sv | 106 ++++++++++
 tb/tb_program_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: receives a LEN/payload/CHK byte frame, writes the payload to program
// memory from address 0, and releases the processor once the checksum verifies.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERR} state_t;

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] adr_cnt;
  logic [DATA_W-1:0] xor_acc;
  logic              xfer;

  function automatic logic len_ok(input logic [DATA_W-1:0] len);
    return (len != '0) && (int'(len) <= DEPTH);
  endfunction

  always_comb begin
    in_ready = (state == IDLE) || (state == LOAD) || (state == CHECK);
  end

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      adr_cnt   <= '0;
      xor_acc   <= '0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // restart wins over any byte offered in the same cycle; that byte is dropped
      if (restart) begin
        state    <= IDLE;
        count    <= '0;
        adr_cnt  <= '0;
        xor_acc  <= '0;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
      end else if (xfer) begin
        case (state)
          IDLE: begin
            count   <= (ADDR_W+1)'(in_data);
            xor_acc <= in_data;
            adr_cnt <= '0;
            if (len_ok(in_data)) begin
              state <= LOAD;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          LOAD: begin
            mem_we    <= 1'b1;
            mem_adr   <= adr_cnt;
            mem_wdata <= in_data;
            xor_acc   <= xor_acc ^ in_data;
            count     <= count - 1'b1;
            // hold the address after the last byte so a full frame never wraps to 0
            if (count == (ADDR_W+1)'(1)) begin
              state <= CHECK;
            end else begin
              adr_cnt <= adr_cnt + 1'b1;
            end
          end
          CHECK: begin
            if (in_data == xor_acc) begin
              state    <= RUN;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes are queued as frames are
// driven and checked by a write monitor; status outputs are checked after each step.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       restart = 1'b0;
  logic       mem_we;
  logic [4:0] mem_adr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       error;

  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];

  program_loader #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // write monitor: every mem_we pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_write observed=%0h expected=none", {mem_adr, mem_wdata});
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("write", {19'd0, mem_adr, mem_wdata}, {19'd0, e});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic hold,
                            input logic dn, input logic er);
    chk({tag, "_in_ready"}, in_ready, rdy);
    chk({tag, "_cpu_hold"}, cpu_hold, hold);
    chk({tag, "_done"}, done, dn);
    chk({tag, "_error"}, error, er);
  endtask

  initial begin
    logic [7:0] b, x;

    // reset state while rst is held low
    #12;
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_adr", mem_adr, 5'd0);
    chk("rst_mem_wdata", mem_wdata, 8'd0);
    chk_status("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // good frame
    exp_q.push_back({5'd0, 8'h21});
    exp_q.push_back({5'd1, 8'h42});
    exp_q.push_back({5'd2, 8'h63});
    send(8'h03); send(8'h21); send(8'h42); send(8'h63); send(8'h03);
    chk_status("good", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("good_sb_empty", exp_q.size(), 0);
    do_restart();
    chk_status("restart1", 1'b1, 1'b1, 1'b0, 1'b0);

    // bad checksum
    exp_q.push_back({5'd0, 8'h21});
    exp_q.push_back({5'd1, 8'h42});
    exp_q.push_back({5'd2, 8'h63});
    send(8'h03); send(8'h21); send(8'h42); send(8'h63); send(8'h04);
    chk_status("badchk", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("badchk_sb_empty", exp_q.size(), 0);
    do_restart();

    // illegal lengths
    send(8'h00);
    chk_status("len00", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;
    do_restart();
    chk_status("len00_restart", 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h21);
    chk_status("len21", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;
    do_restart();
    chk_status("len21_restart", 1'b1, 1'b1, 1'b0, 1'b0);

    // full 32-byte frame with random valid gaps
    x = 8'h20;
    send(8'h20);
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      b = 8'($urandom);
      x = x ^ b;
      exp_q.push_back({5'(i), b});
      send(b);
    end
    chk_status("full_chkwait", 1'b1, 1'b1, 1'b0, 1'b0);
    send(x);
    chk_status("full", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_sb_empty", exp_q.size(), 0);

    // restart from RUN, then a one-byte frame
    do_restart();
    chk_status("run_restart", 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({5'd0, 8'h7F});
    send(8'h01); send(8'h7F);
    chk("one_hold_before_chk", cpu_hold, 1'b1);
    send(8'h7E);
    chk_status("one", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("one_sb_empty", exp_q.size(), 0);

    // asynchronous reset mid-load, after 2 of 5 payload bytes
    do_restart();
    exp_q.push_back({5'd0, 8'hA1});
    exp_q.push_back({5'd1, 8'hB2});
    send(8'h05); send(8'hA1); send(8'hB2);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_mem_we", mem_we, 1'b0);
    chk("arst_mem_adr", mem_adr, 5'd0);
    chk("arst_mem_wdata", mem_wdata, 8'd0);
    chk_status("arst", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({5'd0, 8'h11});
    exp_q.push_back({5'd1, 8'h22});
    send(8'h02); send(8'h11); send(8'h22); send(8'h31);
    chk_status("post_arst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_arst_sb_empty", exp_q.size(), 0);

    // restart coincident with a payload transfer drops that byte
    do_restart();
    exp_q.push_back({5'd0, 8'hAA});
    send(8'h03); send(8'hAA);
    in_valid = 1'b1;
    in_data  = 8'hBB;
    restart  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    restart  = 1'b0;
    chk("coinc_mem_we", mem_we, 1'b0);
    chk_status("coinc", 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({5'd0, 8'h55});
    send(8'h01); send(8'h55); send(8'h54);
    chk_status("coinc_next", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
